// File: rtl/rotation_pkg.sv
// ============================================================================
// Module : rotation_pkg
// Brief  : Shared constants, quarter-wave sine table and FSM state type for
//          the rotation controller.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package rotation_pkg;

    localparam int ANGLE_W   = 6;
    localparam int SCALE     = 256;
    localparam int TRIG_W    = 10;
    localparam int QTAB_N    = 17;
    localparam int QMAG_W    = 9;
    localparam int FCNT_W    = 4;
    localparam logic [FCNT_W-1:0] FCNT_MAX = 4'd15;

    typedef enum logic [0:0] {
        ST_CALC  = 1'b0,
        ST_READY = 1'b1
    } state_e;

    // round(256*sin(k*5.625 deg)), k = 0..16
    function automatic logic [QMAG_W-1:0] qtab(input logic [4:0] k);
        logic [QMAG_W-1:0] v;
        case (k)
            5'd0:    v = 9'd0;
            5'd1:    v = 9'd25;
            5'd2:    v = 9'd50;
            5'd3:    v = 9'd74;
            5'd4:    v = 9'd98;
            5'd5:    v = 9'd121;
            5'd6:    v = 9'd142;
            5'd7:    v = 9'd162;
            5'd8:    v = 9'd181;
            5'd9:    v = 9'd198;
            5'd10:   v = 9'd213;
            5'd11:   v = 9'd226;
            5'd12:   v = 9'd237;
            5'd13:   v = 9'd245;
            5'd14:   v = 9'd251;
            5'd15:   v = 9'd255;
            default: v = 9'd256;
        endcase
        return v;
    endfunction

endpackage

`default_nettype wire

// File: rtl/sincos_lut.sv
// ============================================================================
// Module : sincos_lut
// Brief  : Two-stage registered sin/cos lookup with quadrant folding.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module sincos_lut
    import rotation_pkg::*;
#(
    parameter int ANGLE_W = rotation_pkg::ANGLE_W
) (
    input  logic                     CLK,
    input  logic                     RESET,
    input  logic [ANGLE_W-1:0]       angle_i,
    output logic signed [TRIG_W-1:0] sin_o,
    output logic signed [TRIG_W-1:0] cos_o
);

    localparam int QUARTER = 1 << (ANGLE_W - 2);

    logic [ANGLE_W-1:0] w_cos_angle;
    logic [QMAG_W:0]    w_sin_fold;
    logic [QMAG_W:0]    w_cos_fold;

    logic [QMAG_W-1:0]  sin_mag_q, cos_mag_q;
    logic               sin_neg_q, cos_neg_q;

    // Odd quadrants mirror the table index, the lower half-circle negates.
    function automatic logic [QMAG_W:0] fold(input logic [ANGLE_W-1:0] a);
        logic [ANGLE_W-2:0] idx;
        logic [ANGLE_W-2:0] k;
        idx = {1'b0, a[ANGLE_W-3:0]};
        k   = a[ANGLE_W-2] ? ((ANGLE_W-1)'(QUARTER) - idx) : idx;
        return {a[ANGLE_W-1], qtab(5'(k))};
    endfunction

    assign w_cos_angle = angle_i + ANGLE_W'(QUARTER);
    assign w_sin_fold  = fold(angle_i);
    assign w_cos_fold  = fold(w_cos_angle);

    always_ff @(posedge CLK) begin
        if (RESET) begin
            sin_mag_q <= '0;
            sin_neg_q <= 1'b0;
            cos_mag_q <= '0;
            cos_neg_q <= 1'b0;
            sin_o     <= '0;
            cos_o     <= '0;
        end else begin
            sin_neg_q <= w_sin_fold[QMAG_W];
            sin_mag_q <= w_sin_fold[QMAG_W-1:0];
            cos_neg_q <= w_cos_fold[QMAG_W];
            cos_mag_q <= w_cos_fold[QMAG_W-1:0];
            sin_o     <= sin_neg_q ? -$signed({1'b0, sin_mag_q}) : $signed({1'b0, sin_mag_q});
            cos_o     <= cos_neg_q ? -$signed({1'b0, cos_mag_q}) : $signed({1'b0, cos_mag_q});
        end
    end

endmodule

`default_nettype wire

// File: rtl/rotation_ctrl.sv
// ============================================================================
// Module : rotation_ctrl
// Brief  : Frame-synchronous rotation angle controller with precomputed
//          sin/cos; manual angle entry compiled in with ROTATION_MANUAL_EN.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module rotation_ctrl
    import rotation_pkg::*;
#(
    parameter int ANGLE_W = rotation_pkg::ANGLE_W
) (
    input  logic                     CLK,
    input  logic                     RESET,
    input  logic [17:0]              iSW,
    input  logic                     iFRAME_SYNC,
    output logic signed [TRIG_W-1:0] oSIN_THETA,
    output logic signed [TRIG_W-1:0] oCOS_THETA,
    output logic [ANGLE_W-1:0]       oANGLE,
    output logic                     oUPDATE,
    output logic                     oBUSY
);

    state_e                    state_q, state_d;
    logic                      calc_cnt_q, calc_cnt_d;
    logic [ANGLE_W-1:0]        pend_angle_q, pend_angle_d;
    logic [ANGLE_W-1:0]        angle_q, angle_d;
    logic signed [TRIG_W-1:0]  sin_q, sin_d;
    logic signed [TRIG_W-1:0]  cos_q, cos_d;
    logic                      upd_q, upd_d;
    logic [FCNT_W-1:0]         fcnt_q, fcnt_d;

    logic [ANGLE_W-1:0]        w_step;
    logic [ANGLE_W-1:0]        w_target;
    logic                      w_due;
    logic                      w_commit;
    logic signed [TRIG_W-1:0]  w_lut_sin, w_lut_cos;

    assign w_step = iSW[1] ? (angle_q - 1'b1) : (angle_q + 1'b1);

`ifdef ROTATION_MANUAL_EN
    assign w_target = iSW[0] ? w_step : iSW[6 +: ANGLE_W];
    assign w_due    = iSW[0] ? (fcnt_q == iSW[5:2]) : (w_target != angle_q);
`else
    assign w_target = iSW[0] ? w_step : angle_q;
    assign w_due    = iSW[0] && (fcnt_q == iSW[5:2]);
`endif

    assign w_commit = (state_q == ST_READY) && iFRAME_SYNC &&
                      (pend_angle_q == w_target) && w_due;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q    <= ST_CALC;
            calc_cnt_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            calc_cnt_q <= calc_cnt_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        calc_cnt_d = calc_cnt_q;
        case (state_q)
            ST_CALC: begin
                if (calc_cnt_q) begin
                    state_d    = ST_READY;
                    calc_cnt_d = 1'b0;
                end else begin
                    calc_cnt_d = 1'b1;
                end
            end
            ST_READY: begin
                if (w_commit || (w_target != pend_angle_q)) begin
                    state_d    = ST_CALC;
                    calc_cnt_d = 1'b0;
                end
            end
            default: begin
                state_d    = ST_CALC;
                calc_cnt_d = 1'b0;
            end
        endcase
    end

    always_comb begin
        oBUSY      = (state_q == ST_CALC);
        oUPDATE    = upd_q;
        oANGLE     = angle_q;
        oSIN_THETA = sin_q;
        oCOS_THETA = cos_q;
    end

    // The target is captured on the first CALC cycle; the LUT then sees a
    // steady angle so its outputs stay valid for the whole READY period.
    always_comb begin
        pend_angle_d = pend_angle_q;
        if ((state_q == ST_CALC) && !calc_cnt_q) begin
            pend_angle_d = w_target;
        end
    end

    sincos_lut #(
        .ANGLE_W (ANGLE_W)
    ) u_lut (
        .CLK     (CLK),
        .RESET   (RESET),
        .angle_i (pend_angle_d),
        .sin_o   (w_lut_sin),
        .cos_o   (w_lut_cos)
    );

    always_comb begin
        angle_d = angle_q;
        sin_d   = sin_q;
        cos_d   = cos_q;
        fcnt_d  = fcnt_q;
        upd_d   = w_commit;
        if (w_commit) begin
            angle_d = pend_angle_q;
            sin_d   = w_lut_sin;
            cos_d   = w_lut_cos;
            fcnt_d  = '0;
        end else if (iFRAME_SYNC && (fcnt_q != FCNT_MAX)) begin
            fcnt_d  = fcnt_q + 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            pend_angle_q <= '0;
            angle_q      <= '0;
            sin_q        <= '0;
            cos_q        <= TRIG_W'(SCALE);
            upd_q        <= 1'b0;
            fcnt_q       <= '0;
        end else begin
            pend_angle_q <= pend_angle_d;
            angle_q      <= angle_d;
            sin_q        <= sin_d;
            cos_q        <= cos_d;
            upd_q        <= upd_d;
            fcnt_q       <= fcnt_d;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_rotation_ctrl.sv
// ============================================================================
// Module : tb_rotation_ctrl
// Brief  : Directed and randomized bench for rotation_ctrl against a
//          trigonometric reference model.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_rotation_ctrl;

    logic              CLK = 1'b0;
    logic              RESET = 1'b1;
    logic [17:0]       iSW = '0;
    logic              iFRAME_SYNC = 1'b0;
    logic signed [9:0] oSIN_THETA, oCOS_THETA;
    logic [5:0]        oANGLE;
    logic              oUPDATE, oBUSY;

    int n_tests = 0;
    int n_fail  = 0;
    int upd_cnt = 0;

    // reference model state
    int m_angle = 0;
    int m_pend  = 0;
    int m_calc  = 2;
    int m_fcnt  = 0;
    int m_upd   = 0;
    bit m_valid = 1'b0;

    localparam real PI = 3.14159265358979;

    rotation_ctrl #(.ANGLE_W(6)) dut (
        .CLK         (CLK),
        .RESET       (RESET),
        .iSW         (iSW),
        .iFRAME_SYNC (iFRAME_SYNC),
        .oSIN_THETA  (oSIN_THETA),
        .oCOS_THETA  (oCOS_THETA),
        .oANGLE      (oANGLE),
        .oUPDATE     (oUPDATE),
        .oBUSY       (oBUSY)
    );

    always #5 CLK = ~CLK;

    task automatic check_val(input string tag, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
        end
    endtask

    function automatic int round_real(input real x);
        if (x >= 0.0) return $rtoi(x + 0.5);
        return -$rtoi(-x + 0.5);
    endfunction

    function automatic int ref_sin(input int a);
        return round_real(256.0 * $sin(real'(a) * 5.625 * PI / 180.0));
    endfunction

    function automatic int ref_cos(input int a);
        return round_real(256.0 * $cos(real'(a) * 5.625 * PI / 180.0));
    endfunction

    function automatic int ref_target();
        if (iSW[0]) return iSW[1] ? (m_angle + 63) % 64 : (m_angle + 1) % 64;
`ifdef ROTATION_MANUAL_EN
        return int'(iSW[11:6]);
`else
        return m_angle;
`endif
    endfunction

    function automatic bit ref_due(input int tgt);
        if (iSW[0]) return m_fcnt == int'(iSW[5:2]);
`ifdef ROTATION_MANUAL_EN
        return tgt != m_angle;
`else
        return 1'b0;
`endif
    endfunction

    // Advance the model by one clock using the inputs that were just sampled.
    task automatic model_step();
        int tgt;
        bit commit;
        tgt = ref_target();
        if (RESET) begin
            m_angle = 0;
            m_fcnt  = 0;
            m_calc  = 2;
            m_upd   = 0;
            m_valid = 1'b1;
            return;
        end
        commit = (m_calc == 0) && iFRAME_SYNC && (m_pend == tgt) && ref_due(tgt);
        m_upd  = int'(commit);
        if (commit) begin
            m_angle = m_pend;
            m_fcnt  = 0;
            m_calc  = 2;
        end else begin
            if (iFRAME_SYNC && m_fcnt < 15) m_fcnt++;
            if (m_calc > 0) begin
                if (m_calc == 2) m_pend = tgt;
                m_calc--;
            end else if (tgt != m_pend) begin
                m_calc = 2;
            end
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        model_step();
        @(negedge CLK);
        if (oUPDATE) upd_cnt++;
        if (m_valid) begin
            check_val("angle", int'(oANGLE), m_angle);
            check_val("sin",   int'(oSIN_THETA), ref_sin(m_angle));
            check_val("cos",   int'(oCOS_THETA), ref_cos(m_angle));
            check_val("update", int'(oUPDATE), m_upd);
            check_val("busy",  int'(oBUSY), int'(m_calc > 0));
        end
    endtask

    task automatic do_reset(input logic [17:0] sw);
        iSW = sw;
        iFRAME_SYNC = 1'b0;
        RESET = 1'b1;
        repeat (2) tick();
        RESET = 1'b0;
        repeat (4) tick();
        upd_cnt = 0;
    endtask

    task automatic sync_gap(input int n);
        iFRAME_SYNC = 1'b1;
        tick();
        iFRAME_SYNC = 1'b0;
        repeat (n - 1) tick();
    endtask

    initial begin
        @(negedge CLK);

        // reset values
        iSW = '0;
        RESET = 1'b1;
        repeat (2) tick();
        check_val("rst_angle", int'(oANGLE), 0);
        check_val("rst_sin", int'(oSIN_THETA), 0);
        check_val("rst_cos", int'(oCOS_THETA), 256);
        check_val("rst_upd", int'(oUPDATE), 0);
        RESET = 1'b0;

        // auto up, one step per frame
        do_reset(18'h00001);
        repeat (8) sync_gap(10);
        check_val("up8_pulses", upd_cnt, 8);
        check_val("up8_angle", int'(oANGLE), 8);
        check_val("up8_sin", int'(oSIN_THETA), 181);
        check_val("up8_cos", int'(oCOS_THETA), 181);

        // auto up, four frames per step
        do_reset(18'h00001 | (18'd3 << 2));
        repeat (3) sync_gap(10);
        check_val("fps4_nopulse", upd_cnt, 0);
        sync_gap(10);
        check_val("fps4_angle", int'(oANGLE), 1);
        check_val("fps4_sin", int'(oSIN_THETA), 25);
        check_val("fps4_cos", int'(oCOS_THETA), 255);

        // auto down from 0 with wrap
        do_reset(18'h00003);
        sync_gap(10);
        check_val("dn_angle", int'(oANGLE), 63);
        check_val("dn_sin", int'(oSIN_THETA), -25);
        check_val("dn_cos", int'(oCOS_THETA), 255);
        repeat (15) sync_gap(10);
        check_val("dn48_angle", int'(oANGLE), 48);
        check_val("dn48_sin", int'(oSIN_THETA), -256);
        check_val("dn48_cos", int'(oCOS_THETA), 0);

        // sync right after a commit lands in CALC and is only counted
        do_reset(18'h00001 | (18'd1 << 2));
        sync_gap(10);
        iFRAME_SYNC = 1'b1;
        tick();
        tick();
        iFRAME_SYNC = 1'b0;
        repeat (8) tick();
        check_val("calc_sync_pulses", upd_cnt, 1);
        check_val("calc_sync_angle", int'(oANGLE), 1);
        sync_gap(10);
        check_val("ready_sync_pulses", upd_cnt, 2);
        check_val("ready_sync_angle", int'(oANGLE), 2);

        // manual angle entry
        do_reset(18'd32 << 6);
        sync_gap(10);
`ifdef ROTATION_MANUAL_EN
        check_val("man_angle", int'(oANGLE), 32);
        check_val("man_sin", int'(oSIN_THETA), 0);
        check_val("man_cos", int'(oCOS_THETA), -256);
`else
        check_val("hold_angle", int'(oANGLE), 0);
        check_val("hold_upd", upd_cnt, 0);
`endif

        // randomized traffic against the model
        do_reset(18'h00001);
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(63) == 0) iSW = 18'($urandom);
            iFRAME_SYNC = ($urandom_range(7) == 0);
            RESET = ($urandom_range(499) == 0);
            tick();
        end
        RESET = 1'b0;
        iFRAME_SYNC = 1'b0;
        repeat (4) tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
